// File: rtl/exp2_highacc.sv
// Fixed-point base-2 antilog: 4.8 unsigned log code in, 16.8 linear value out.
// Three-stage pipeline (table lookup, interpolation, shift/round/clamp) with clock-enable stall.
module exp2_highacc #(
  parameter int LUT_BITS    = 6,
  parameter int INTERP_BITS = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce,
  input  logic        in_valid,
  input  logic [11:0] DIN_LOG,
  output logic        out_valid,
  output logic [23:0] DOUT_LIN
);

  localparam int FRAC_BITS = LUT_BITS + INTERP_BITS;
  localparam int INT_BITS  = 12 - FRAC_BITS;
  localparam int MANT_W    = 17;
  localparam int PROD_W    = MANT_W + INTERP_BITS;
  localparam int SHIFT_W   = 32;

  // Mantissa table in 1.15 format: round(32768 * 2^(k/64)), k = 0..64.
  function automatic logic [MANT_W-1:0] mant_lut(input logic [6:0] k);
    logic [MANT_W-1:0] m;
    m = 17'd65536;
    case (k)
      7'd0:  m = 17'd32768;  7'd1:  m = 17'd33125;  7'd2:  m = 17'd33486;  7'd3:  m = 17'd33850;
      7'd4:  m = 17'd34219;  7'd5:  m = 17'd34591;  7'd6:  m = 17'd34968;  7'd7:  m = 17'd35349;
      7'd8:  m = 17'd35734;  7'd9:  m = 17'd36123;  7'd10: m = 17'd36516;  7'd11: m = 17'd36914;
      7'd12: m = 17'd37316;  7'd13: m = 17'd37722;  7'd14: m = 17'd38133;  7'd15: m = 17'd38548;
      7'd16: m = 17'd38968;  7'd17: m = 17'd39392;  7'd18: m = 17'd39821;  7'd19: m = 17'd40255;
      7'd20: m = 17'd40693;  7'd21: m = 17'd41136;  7'd22: m = 17'd41584;  7'd23: m = 17'd42037;
      7'd24: m = 17'd42495;  7'd25: m = 17'd42958;  7'd26: m = 17'd43425;  7'd27: m = 17'd43898;
      7'd28: m = 17'd44376;  7'd29: m = 17'd44859;  7'd30: m = 17'd45348;  7'd31: m = 17'd45842;
      7'd32: m = 17'd46341;  7'd33: m = 17'd46846;  7'd34: m = 17'd47356;  7'd35: m = 17'd47871;
      7'd36: m = 17'd48393;  7'd37: m = 17'd48920;  7'd38: m = 17'd49452;  7'd39: m = 17'd49991;
      7'd40: m = 17'd50535;  7'd41: m = 17'd51085;  7'd42: m = 17'd51642;  7'd43: m = 17'd52204;
      7'd44: m = 17'd52773;  7'd45: m = 17'd53347;  7'd46: m = 17'd53928;  7'd47: m = 17'd54515;
      7'd48: m = 17'd55109;  7'd49: m = 17'd55709;  7'd50: m = 17'd56316;  7'd51: m = 17'd56929;
      7'd52: m = 17'd57549;  7'd53: m = 17'd58176;  7'd54: m = 17'd58809;  7'd55: m = 17'd59449;
      7'd56: m = 17'd60097;  7'd57: m = 17'd60751;  7'd58: m = 17'd61413;  7'd59: m = 17'd62081;
      7'd60: m = 17'd62757;  7'd61: m = 17'd63441;  7'd62: m = 17'd64132;  7'd63: m = 17'd64830;
      7'd64: m = 17'd65536;
      default: m = 17'd65536;
    endcase
    return m;
  endfunction

  // Stage 1: split the code and fetch both interpolation endpoints.
  logic                   s1_valid_q;
  logic [INT_BITS-1:0]    s1_int_q,  s1_int_d;
  logic [INTERP_BITS-1:0] s1_frac_q, s1_frac_d;
  logic [MANT_W-1:0]      s1_a_q,    s1_a_d;
  logic [MANT_W-1:0]      s1_b_q,    s1_b_d;

  // Stage 2: interpolated mantissa.
  logic                   s2_valid_q;
  logic [INT_BITS-1:0]    s2_int_q;
  logic [MANT_W-1:0]      s2_mant_q, s2_mant_d;

  // Stage 3: scaled, rounded, clamped output.
  logic                   s3_valid_q;
  logic [23:0]            s3_lin_q,  s3_lin_d;

  logic [LUT_BITS-1:0]    idx;
  logic [PROD_W-1:0]      delta_prod;
  logic [SHIFT_W-1:0]     shifted;
  logic [SHIFT_W:0]       rounded;

  always_comb begin
    idx       = DIN_LOG[FRAC_BITS-1:INTERP_BITS];
    s1_int_d  = DIN_LOG[11:FRAC_BITS];
    s1_frac_d = DIN_LOG[INTERP_BITS-1:0];
    s1_a_d    = mant_lut({1'b0, idx});
    s1_b_d    = mant_lut({1'b0, idx} + 7'd1);
  end

  // Table is increasing, so b - a never underflows; the shift truncates.
  always_comb begin
    delta_prod = PROD_W'(s1_b_q - s1_a_q) * PROD_W'(s1_frac_q);
    s2_mant_d  = MANT_W'(PROD_W'(s1_a_q) + (delta_prod >> INTERP_BITS));
  end

  // Adding half of the 2^-8 LSB before the shift gives round-half-up.
  always_comb begin
    shifted  = SHIFT_W'(s2_mant_q) << s2_int_q;
    rounded  = ((SHIFT_W + 1)'(shifted) + 33'd64) >> 7;
    s3_lin_d = (|rounded[SHIFT_W:24]) ? 24'hFF_FFFF : rounded[23:0];
  end

  // NOTE: every pipeline register, data included, is cleared by reset so the
  // outputs read a defined zero; all state updates use non-blocking assignments.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_int_q   <= '0;
      s1_frac_q  <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_int_q   <= '0;
      s2_mant_q  <= '0;
      s3_valid_q <= 1'b0;
      s3_lin_q   <= '0;
    end else if (ce) begin
      s1_valid_q <= in_valid;
      s1_int_q   <= s1_int_d;
      s1_frac_q  <= s1_frac_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s2_valid_q <= s1_valid_q;
      s2_int_q   <= s1_int_q;
      s2_mant_q  <= s2_mant_d;
      s3_valid_q <= s2_valid_q;
      s3_lin_q   <= s3_lin_d;
    end
  end

  assign out_valid = s3_valid_q;
  assign DOUT_LIN  = s3_lin_q;

endmodule

// File: tb/tb_exp2_highacc.sv
// Directed bench for exp2_highacc: exact powers, table/rounding points, stall,
// bubbles, async reset mid-stream, and a full-range sweep against a real-valued model.
module tb_exp2_highacc;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ce;
  logic        in_valid;
  logic [11:0] din_log;
  logic        out_valid;
  logic [23:0] dout_lin;

  int n_checks = 0;
  int n_pass   = 0;

  bit          s_vld[$];
  logic [11:0] s_din[$];
  logic [23:0] s_exp[$];

  exp2_highacc dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ce       (ce),
    .in_valid (in_valid),
    .DIN_LOG  (din_log),
    .out_valid(out_valid),
    .DOUT_LIN (dout_lin)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [11:0] d);
    in_valid = v;
    din_log  = d;
  endtask

  task automatic add(input bit v, input logic [11:0] d, input logic [23:0] e);
    s_vld.push_back(v);
    s_din.push_back(d);
    s_exp.push_back(e);
  endtask

  // Back-to-back issue with ce=1; each sample must appear after its third edge.
  task automatic run_stream(input string name);
    int n;
    n = s_din.size();
    for (int k = 0; k < n + 2; k++) begin
      if (k < n) drive(s_vld[k], s_din[k]);
      else       drive(1'b0, 12'h000);
      tick();
      if (k >= 2) begin
        check($sformatf("%s[%0d].valid", name, k - 2), 32'(out_valid), 32'(s_vld[k-2]));
        if (s_vld[k-2])
          check($sformatf("%s[%0d].dout", name, k - 2), 32'(dout_lin), 32'(s_exp[k-2]));
      end
    end
    s_vld.delete();
    s_din.delete();
    s_exp.delete();
  endtask

  initial begin
    reset_n = 1'b0;
    ce      = 1'b0;
    drive(1'b0, 12'h000);
    #1;
    check("reset_async.valid", 32'(out_valid), 32'd0);
    check("reset_async.dout",  32'(dout_lin),  32'd0);
    repeat (3) tick();
    check("reset_held.valid", 32'(out_valid), 32'd0);
    check("reset_held.dout",  32'(dout_lin),  32'd0);

    #2;
    reset_n = 1'b1;
    ce      = 1'b1;

    add(1'b1, 12'h000, 24'h000100);
    add(1'b1, 12'h100, 24'h000200);
    add(1'b1, 12'h800, 24'h010000);
    add(1'b1, 12'hF00, 24'h800000);
    run_stream("powers");

    add(1'b1, 12'h080, 24'h00016A);
    add(1'b1, 12'hFFF, 24'hFF4F00);
    add(1'b1, 12'h0FF, 24'h0001FF);
    add(1'b1, 12'h001, 24'h000101);
    add(1'b1, 12'h7FF, 24'h00FF4F);
    run_stream("table");

    add(1'b1, 12'h100, 24'h000200);
    add(1'b0, 12'h2AB, 24'h000000);
    add(1'b1, 12'h200, 24'h000400);
    add(1'b0, 12'h3CD, 24'h000000);
    run_stream("bubbles");

    // Stall: bubbles of code 0 leave a known 0x000100 in the output stage.
    drive(1'b0, 12'h000);
    repeat (3) tick();
    check("bubble_content.valid", 32'(out_valid), 32'd0);
    check("bubble_content.dout",  32'(dout_lin),  32'h000100);
    drive(1'b1, 12'h100); tick();
    drive(1'b1, 12'h200); tick();
    ce = 1'b0;
    drive(1'b1, 12'hABC);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("stall[%0d].valid", i), 32'(out_valid), 32'd0);
      check($sformatf("stall[%0d].dout", i),  32'(dout_lin),  32'h000100);
    end
    ce = 1'b1;
    drive(1'b1, 12'h300); tick();
    check("resume0.valid", 32'(out_valid), 32'd1);
    check("resume0.dout",  32'(dout_lin),  32'h000200);
    ce = 1'b0;
    drive(1'b0, 12'hFFF); tick();
    check("hold_valid.valid", 32'(out_valid), 32'd1);
    check("hold_valid.dout",  32'(dout_lin),  32'h000200);
    ce = 1'b1;
    drive(1'b0, 12'h000); tick();
    check("resume1.valid", 32'(out_valid), 32'd1);
    check("resume1.dout",  32'(dout_lin),  32'h000400);
    tick();
    check("resume2.valid", 32'(out_valid), 32'd1);
    check("resume2.dout",  32'(dout_lin),  32'h000800);
    tick();
    check("resume3.valid", 32'(out_valid), 32'd0);

    // Async reset with three samples in flight.
    drive(1'b1, 12'h100); tick();
    drive(1'b1, 12'h200); tick();
    drive(1'b1, 12'h300); tick();
    check("inflight.valid", 32'(out_valid), 32'd1);
    check("inflight.dout",  32'(dout_lin),  32'h000200);
    #2;
    reset_n = 1'b0;
    #1;
    check("midreset.valid", 32'(out_valid), 32'd0);
    check("midreset.dout",  32'(dout_lin),  32'd0);
    drive(1'b1, 12'h500); tick();
    check("midreset_edge.valid", 32'(out_valid), 32'd0);
    #2;
    reset_n = 1'b1;
    drive(1'b1, 12'h400); tick();
    check("post_reset0.valid", 32'(out_valid), 32'd0);
    drive(1'b0, 12'h000); tick();
    check("post_reset1.valid", 32'(out_valid), 32'd0);
    tick();
    check("post_reset2.valid", 32'(out_valid), 32'd1);
    check("post_reset2.dout",  32'(dout_lin),  32'h001000);

    // Full sweep against round(256 * 2^(x/256)), plus monotonicity.
    begin
      int   prev;
      int   gold;
      int   got;
      int   diff;
      real  g;
      bit   in_tol;
      prev = 0;
      for (int k = 0; k < 4096 + 2; k++) begin
        if (k < 4096) drive(1'b1, 12'(k));
        else          drive(1'b0, 12'h000);
        tick();
        if (k >= 2) begin
          g      = 256.0 * (2.0 ** (real'(k - 2) / 256.0));
          gold   = $rtoi($floor(g + 0.5));
          got    = int'(dout_lin);
          diff   = (got > gold) ? got - gold : gold - got;
          in_tol = (diff <= 1) || (diff * 1000 <= gold);
          check($sformatf("sweep x=%03h valid", k - 2), 32'(out_valid), 32'd1);
          check($sformatf("sweep x=%03h got=%06h gold=%06h", k - 2, got, gold),
                32'(in_tol), 32'd1);
          check($sformatf("mono x=%03h got=%06h prev=%06h", k - 2, got, prev),
                32'(got >= prev), 32'd1);
          prev = got;
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
